// File: rtl/chg_txt_sender_if.sv
// Bundle of the change-SRAM read port and the change-record handshake
// between the change-text sender and the Y-matrix integrator side.
interface chg_txt_sender_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [79:0]       mem_rdata;
    logic              chg_valid;
    logic [15:0]       chg_row;
    logic [15:0]       chg_col;
    logic [23:0]       chg_real;
    logic [23:0]       chg_img;
    logic              chg_done;

    // Sender side: drives the SRAM address/strobe and the record outputs.
    modport master (
        output mem_addr, mem_rd_en, chg_valid, chg_row, chg_col, chg_real, chg_img,
        input  mem_rdata, chg_done
    );

    // SRAM/integrator side: returns read data and acknowledges records.
    modport slave (
        input  mem_addr, mem_rd_en, chg_valid, chg_row, chg_col, chg_real, chg_img,
        output mem_rdata, chg_done
    );
endinterface

// File: rtl/chg_txt_sender.sv
// chg_txt_sender: walks the change SRAM from address 0, presenting one packed
// record (row, col, real, img) at a time and holding it until the integrator
// acknowledges it. A run ends on a sentinel row or after MAX_RECS records.
// All outputs are registered; they are derived from the next state so that
// each output is valid in the same cycle as the state it belongs to.
module chg_txt_sender #(
    parameter int          ADDR_W   = 10,
    parameter int          MAX_RECS = 1023,
    parameter logic [15:0] SENTINEL = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    chg_txt_sender_if.master  bus,
    output logic              busy,
    output logic              all_done,
    output logic [ADDR_W-1:0] rec_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT_RD = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] MAX_C = MAX_RECS[ADDR_W-1:0];

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] rec_count_r;
    logic [ADDR_W-1:0] count_inc_s;
    logic              mem_rd_en_r;
    logic              chg_valid_r;
    logic              busy_r;
    logic              all_done_r;
    logic [15:0]       chg_row_r;
    logic [15:0]       chg_col_r;
    logic [23:0]       chg_real_r;
    logic [23:0]       chg_img_r;
    logic              ack_s;

    // An acknowledge only counts while a record is actually being presented.
    assign ack_s       = (state_r == S_PRESENT) && bus.chg_done;
    assign count_inc_s = rec_count_r + ONE;

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_rd_en = mem_rd_en_r;
    assign bus.chg_valid = chg_valid_r;
    assign bus.chg_row   = chg_row_r;
    assign bus.chg_col   = chg_col_r;
    assign bus.chg_real  = chg_real_r;
    assign bus.chg_img   = chg_img_r;
    assign busy          = busy_r;
    assign all_done      = all_done_r;
    assign rec_count     = rec_count_r;

    // Next-state decode; the record limit wins over fetching another record.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_nxt_s = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (bus.mem_rdata[79:64] == SENTINEL) begin
                    state_nxt_s = S_FINISH;
                end else begin
                    state_nxt_s = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (!ack_s) begin
                    state_nxt_s = S_PRESENT;
                end else if (count_inc_s == MAX_C) begin
                    state_nxt_s = S_FINISH;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_FINISH: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, registered status outputs, address/count bookkeeping and record capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            mem_addr_r  <= {ADDR_W{1'b0}};
            rec_count_r <= {ADDR_W{1'b0}};
            mem_rd_en_r <= 1'b0;
            chg_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            all_done_r  <= 1'b0;
            chg_row_r   <= 16'h0000;
            chg_col_r   <= 16'h0000;
            chg_real_r  <= 24'h000000;
            chg_img_r   <= 24'h000000;
        end else begin
            state_r     <= state_nxt_s;
            mem_rd_en_r <= (state_nxt_s == S_FETCH);
            chg_valid_r <= (state_nxt_s == S_PRESENT);
            all_done_r  <= (state_nxt_s == S_FINISH);
            busy_r      <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_WAIT_RD) ||
                           (state_nxt_s == S_PRESENT);
            if ((state_r == S_IDLE) && start) begin
                mem_addr_r  <= {ADDR_W{1'b0}};
                rec_count_r <= {ADDR_W{1'b0}};
            end else if (ack_s) begin
                mem_addr_r  <= mem_addr_r + ONE;
                rec_count_r <= count_inc_s;
            end
            // The sentinel record is captured too; the data registers simply
            // keep whatever was read last.
            if (state_r == S_WAIT_RD) begin
                chg_row_r  <= bus.mem_rdata[79:64];
                chg_col_r  <= bus.mem_rdata[63:48];
                chg_real_r <= bus.mem_rdata[47:24];
                chg_img_r  <= bus.mem_rdata[23:0];
            end
        end
    end
endmodule
